// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
//   Single-clock AXI-Stream FIFO with optional store-and-forward packet mode.
//   In packet mode the consumer only ever sees complete packets; a packet that
//   cannot fit in the storage is discarded in its entirety and flagged on drop.
//
// Ports
//   aclk, areset          clock (rising edge), asynchronous active-high reset
//   m_data/m_valid/m_last write beat from upstream; m_ready back-pressure
//   s_data/s_valid/s_last read beat to the consumer; s_ready from consumer
//   level                 entries held, committed and uncommitted
//   pkt_count             committed packets not yet fully read
//   drop                  one-cycle pulse when an oversize packet is discarded
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_DEPTH  = 4,
  parameter bit PACKET_MODE = 1'b1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic                  m_last,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic                  s_last,
  output logic [ADDR_DEPTH:0]   level,
  output logic [ADDR_DEPTH:0]   pkt_count,
  output logic                  drop
);

  localparam int DEPTH = 2 ** ADDR_DEPTH;
  localparam logic [ADDR_DEPTH:0] FullCount = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0] DropCount = (ADDR_DEPTH+1)'(DEPTH - 1);
  localparam logic [ADDR_DEPTH:0] One       = (ADDR_DEPTH+1)'(1);

  typedef enum logic {
    StNormal,
    StDrop
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_DEPTH:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_DEPTH:0]   commitPtr_q, commitPtr_d;
  logic [ADDR_DEPTH:0]   rdPtr_q, rdPtr_d;
  logic [ADDR_DEPTH:0]   pktCount_q, pktCount_d;
  logic                  drop_q, drop_d;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DATA_WIDTH:0]   rdEntry;
  logic [ADDR_DEPTH:0]   uncommitted;
  logic                  full;
  logic                  wrEn;
  logic                  rdEn;
  logic                  memWe;
  logic                  pktInc;
  logic                  pktDec;

  assign full        = (wrPtr_q - rdPtr_q) == FullCount;
  assign uncommitted = wrPtr_q - commitPtr_q;

  // In DROP every beat is swallowed, so back-pressure is lifted regardless of fill.
  assign m_ready = areset ? 1'b0 : ((state_q == StDrop) ? 1'b1 : !full);
  assign wrEn    = m_valid && m_ready;

  // Only committed entries are visible; data and last are zeroed when idle.
  assign rdEntry = mem[rdPtr_q[ADDR_DEPTH-1:0]];
  assign s_valid = rdPtr_q != commitPtr_q;
  assign s_data  = s_valid ? rdEntry[DATA_WIDTH-1:0] : '0;
  assign s_last  = s_valid ? rdEntry[DATA_WIDTH] : 1'b0;
  assign rdEn    = s_valid && s_ready;
  assign pktDec  = rdEn && s_last;

  assign level     = wrPtr_q - rdPtr_q;
  assign pkt_count = pktCount_q;
  assign drop      = drop_q;

  // Next-state logic. A non-last beat arriving when DEPTH-1 beats of the
  // current packet are already held means the packet can never commit, so the
  // partial packet is rewound and the remainder is discarded in DROP.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    commitPtr_d = commitPtr_q;
    rdPtr_d     = rdPtr_q;
    pktCount_d  = pktCount_q;
    drop_d      = 1'b0;
    memWe       = 1'b0;
    pktInc      = 1'b0;

    if (wrEn) begin
      if (state_q == StDrop) begin
        if (m_last) begin
          state_d = StNormal;
        end
      end else if (PACKET_MODE && !m_last && (uncommitted == DropCount)) begin
        state_d = StDrop;
        wrPtr_d = commitPtr_q;
        drop_d  = 1'b1;
      end else begin
        memWe   = 1'b1;
        wrPtr_d = wrPtr_q + One;
        if (!PACKET_MODE || m_last) begin
          commitPtr_d = wrPtr_q + One;
        end
        pktInc = m_last;
      end
    end

    if (rdEn) begin
      rdPtr_d = rdPtr_q + One;
    end

    case ({pktInc, pktDec})
      2'b10:   pktCount_d = pktCount_q + One;
      2'b01:   pktCount_d = pktCount_q - One;
      default: pktCount_d = pktCount_q;
    endcase
  end

  // Control state and pointers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StNormal;
      wrPtr_q     <= '0;
      commitPtr_q <= '0;
      rdPtr_q     <= '0;
      pktCount_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      commitPtr_q <= commitPtr_d;
      rdPtr_q     <= rdPtr_d;
      pktCount_q  <= pktCount_d;
      drop_q      <= drop_d;
    end
  end

  // Storage array is not reset; pointers alone define what is valid.
  always_ff @(posedge aclk) begin
    if (memWe) begin
      mem[wrPtr_q[ADDR_DEPTH-1:0]] <= {m_last, m_data};
    end
  end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised single-clock AXI-Stream FIFO with selectable store-and-forward packet mode, fill-level and packet-count status, and oversize-packet drop. It replaces the fixed 8-bit/16-entry stream FIFO wherever a downstream consumer must only see complete packets. Upstream drives the m_* side into the block; the block drives the s_* side out to the consumer.

## Interface
- DATA_WIDTH, 8: width of m_data / s_data.
- ADDR_DEPTH, 4: log2 of storage depth; DEPTH = 2**ADDR_DEPTH entries.
- PACKET_MODE, 1: 1 = store-and-forward (output only sees committed packets); 0 = plain cut-through FIFO.
- aclk  in  1  single clock, all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- m_data  in  DATA_WIDTH  write beat data.
- m_valid  in  1  write beat valid.
- m_ready  out  1  block can accept a beat.
- m_last  in  1  final beat of packet.
- s_data  out  DATA_WIDTH  read beat data; forced 0 when s_valid=0.
- s_valid  out  1  read beat available.
- s_ready  in  1  consumer accepts beat.
- s_last  out  1  final beat of packet; forced 0 when s_valid=0.
- level  out  ADDR_DEPTH+1  entries held, including uncommitted beats.
- pkt_count  out  ADDR_DEPTH+1  committed packets not yet fully read.
- drop  out  1  one-cycle pulse: an oversize packet was discarded.

## Operation
- Storage: DEPTH x (DATA_WIDTH+1) register array {last, data}; asynchronous read, no reset on the array.
- Pointers wr_ptr, commit_ptr, rd_ptr: ADDR_DEPTH+1 bits each; the low ADDR_DEPTH bits address the array; the MSB disambiguates full and empty. Wrap-around is natural modulo 2**(ADDR_DEPTH+1).
- Write handshake: beat accepted when m_valid && m_ready; stored at wr_ptr, wr_ptr+1.
- full = (wr_ptr - rd_ptr) == DEPTH; m_ready = !full in state NORMAL, 1 in state DROP, 0 while areset is high.
- Read handshake: s_valid = (rd_ptr != commit_ptr); beat consumed when s_valid && s_ready, rd_ptr+1.
- PACKET_MODE=0: commit_ptr follows wr_ptr on every accepted beat.
- PACKET_MODE=1: commit_ptr <= wr_ptr+1 only on an accepted beat with m_last=1.
- pkt_count: +1 on each accepted m_last beat in NORMAL (both modes), -1 on each consumed s_last beat; both in the same cycle leave it unchanged.
- level = wr_ptr - rd_ptr.
- State machine (PACKET_MODE=1 only; PACKET_MODE=0 stays in NORMAL):
  - NORMAL: if a beat with m_last=0 is accepted while (wr_ptr - commit_ptr) == DEPTH-1, go to DROP, set wr_ptr <= commit_ptr, and pulse drop next cycle.
  - DROP: accept and discard all beats without writing or changing the pointers; on an accepted m_last beat, return to NORMAL; pkt_count is not incremented.
- A packet of exactly DEPTH beats is legal (its last beat carries m_last=1), is committed, and is not dropped.

## Timing
- Reset (asynchronous assert): pointers 0, state NORMAL, s_valid 0, s_data 0, s_last 0, level 0, pkt_count 0, drop 0, m_ready 0.
- m_ready rises in the first cycle after areset deasserts.
- Reset mid-packet discards all contents, committed and uncommitted.
- PACKET_MODE=0 latency: a beat accepted at edge N gives s_valid=1 after edge N, so it is readable in the next cycle.
- PACKET_MODE=1 latency: the first beat of a packet becomes visible after the edge that accepts its m_last beat; earlier beats never raise s_valid.
- Simultaneous write and read: both occur and level is unchanged. When full, the write is blocked (m_ready=0) but the read proceeds; m_ready rises the cycle after the read.
- Empty or uncommitted-only: s_valid=0, and s_ready is ignored.
- drop is high for exactly one cycle, the cycle after the offending beat's edge.
- Status outputs (level, pkt_count) are registered or derived from registered pointers, and update after the edge causing the change.

## Test plan
- Reset/idle: assert areset for 3 cycles, then release -> all outputs 0 during reset, m_ready=1 from the 1st cycle after release, s_valid stays 0.
- FIFO mode (PACKET_MODE=0), s_ready=0: write 16 beats 0x01..0x10 -> m_ready=0 after the 16th, level=16; then s_ready=1 -> 0x01..0x10 read in order, one per cycle, level returns to 0.
- Packet mode: write 5 beats 0xA0..0xA4 with m_last on 0xA4 -> s_valid=0 until the edge accepting 0xA4, then 0xA0..0xA4 out with s_last on 0xA4; pkt_count goes 0→1→0.
- Exact-depth packet: 16 beats with m_last on the 16th -> no drop, pkt_count=1, all 16 beats read back.
- Oversize drop: 20 beats 0x00..0x13 with m_last on the 20th, s_ready=0 -> drop pulses once after the 16th beat, m_ready stays 1 through the 20th, level=0, pkt_count=0, s_valid=0; then a 2-beat packet 0x55,0x66 reads back intact.
- Concurrency and wrap: stream 3 packets of 7 beats with s_ready=1 continuously -> pointers wrap, packets emerge in order without loss, and a simultaneous commit plus s_last leaves pkt_count unchanged.
